// File: rtl/xc_malu_pkg.sv
// Shared definitions for the multi-cycle ALU divide/remainder path:
// op encodings, iteration count and sequencer state encoding.
package xc_malu_pkg;

    typedef enum logic [1:0] {
        XC_DIV  = 2'b00,
        XC_DIVU = 2'b01,
        XC_REM  = 2'b10,
        XC_REMU = 2'b11
    } xc_op_e;

    localparam int unsigned DIV_STEPS = 32;
    // Wide enough to hold DIV_STEPS itself, where the step core reports ready.
    localparam int unsigned COUNT_W   = $clog2(DIV_STEPS) + 1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } divrem_state_e;

    function automatic logic op_is_signed(xc_op_e op);
        return (op == XC_DIV) || (op == XC_REM);
    endfunction

    function automatic logic op_is_rem(xc_op_e op);
        return (op == XC_REM) || (op == XC_REMU);
    endfunction

endpackage

// File: rtl/xc_malu_divrem_seq_if.sv
// Request/response handshake bundle between an issuing unit (master) and the
// divide/remainder sequencer (slave).
interface xc_malu_divrem_seq_if;
    import xc_malu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );

endinterface

// File: rtl/xc_malu_divrem_fixup.sv
// Turns the unsigned quotient/remainder from the step core into the final
// RISC-V result: sign correction and the divide-by-zero convention.
module xc_malu_divrem_fixup
    import xc_malu_pkg::*;
(
    input  xc_op_e      op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] arg_0,
    input  logic [31:0] arg_1,
    output logic [31:0] result
);

    logic        sgn;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] q;
    logic [31:0] r;

    always_comb begin
        sgn   = op_is_signed(op);
        neg_q = sgn && (rs1[31] ^ rs2[31]);
        neg_r = sgn && rs1[31];
        q     = neg_q ? -arg_1 : arg_1;
        r     = neg_r ? -arg_0 : arg_0;
        // Divide by zero is fixed explicitly: the sign rule would mangle it.
        if (rs2 == 32'd0) begin
            result = op_is_rem(op) ? rs1 : 32'hFFFF_FFFF;
        end else begin
            result = op_is_rem(op) ? r : q;
        end
    end

endmodule

// File: rtl/xc_malu_divrem_seq.sv
// Divide/remainder sequencer: owns the step-core state registers, walks
// IDLE -> RUN -> FIX -> DONE and returns one result per accepted request.
module xc_malu_divrem_seq
    import xc_malu_pkg::*;
#(
    parameter bit BYPASS_DIV0 = 1'b1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 flush,
    xc_malu_divrem_seq_if.slave  bus,
    output logic                 step_valid,
    output logic                 step_signed,
    output logic                 step_flush,
    output logic [31:0]          step_rs1,
    output logic [31:0]          step_rs2,
    output logic [COUNT_W-1:0]   step_count,
    output logic [63:0]          step_acc,
    output logic [31:0]          step_arg_0,
    output logic [31:0]          step_arg_1,
    input  logic [63:0]          step_n_acc,
    input  logic [31:0]          step_n_arg_0,
    input  logic [31:0]          step_n_arg_1,
    input  logic                 step_ready
);

    divrem_state_e      state_d, state_q;
    xc_op_e             op_d, op_q;
    logic [31:0]        rs1_d, rs1_q;
    logic [31:0]        rs2_d, rs2_q;
    logic [COUNT_W-1:0] count_d, count_q;
    logic [63:0]        acc_d, acc_q;
    logic [31:0]        arg_0_d, arg_0_q;
    logic [31:0]        arg_1_d, arg_1_q;
    logic [31:0]        result_d, result_q;
    logic               first_d, first_q;
    logic [31:0]        fix_result;

    xc_malu_divrem_fixup u_fixup (
        .op     (op_q),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .arg_0  (arg_0_q),
        .arg_1  (arg_1_q),
        .result (fix_result)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        count_d  = count_q;
        acc_d    = acc_q;
        arg_0_d  = arg_0_q;
        arg_1_d  = arg_1_q;
        result_d = result_q;
        first_d  = first_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d    = xc_op_e'(bus.req_op);
                    rs1_d   = bus.req_rs1;
                    rs2_d   = bus.req_rs2;
                    count_d = '0;
                    acc_d   = '0;
                    arg_0_d = '0;
                    arg_1_d = '0;
                    if (BYPASS_DIV0 && (bus.req_rs2 == 32'd0)) begin
                        state_d = StFix;
                    end else begin
                        state_d = StRun;
                        first_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (step_ready) begin
                    state_d = StFix;
                end else begin
                    acc_d   = step_n_acc;
                    arg_0_d = step_n_arg_0;
                    arg_1_d = step_n_arg_1;
                    // The start cycle loads initial values; counting begins after it.
                    count_d = first_q ? '0 : count_q + COUNT_W'(1);
                    first_d = 1'b0;
                end
            end
            StFix: begin
                result_d = fix_result;
                state_d  = StDone;
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
        if (flush) begin
            state_d  = StIdle;
            count_d  = '0;
            acc_d    = '0;
            arg_0_d  = '0;
            arg_1_d  = '0;
            result_d = '0;
            first_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            op_q     <= XC_DIV;
            rs1_q    <= '0;
            rs2_q    <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            arg_0_q  <= '0;
            arg_1_q  <= '0;
            result_q <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            arg_0_q  <= arg_0_d;
            arg_1_q  <= arg_1_d;
            result_q <= result_d;
            first_q  <= first_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.rsp_valid  = (state_q == StDone);
    assign bus.rsp_result = result_q;

    assign step_valid  = (state_q == StRun);
    assign step_signed = op_is_signed(op_q);
    assign step_flush  = flush;
    assign step_rs1    = rs1_q;
    assign step_rs2    = rs2_q;
    assign step_count  = count_q;
    assign step_acc    = acc_q;
    assign step_arg_0  = arg_0_q;
    assign step_arg_1  = arg_1_q;

endmodule

// File: tb/tb_xc_malu_divrem_seq.sv
// Bench for the divide/remainder sequencer, with a behavioural restoring
// step core standing in for the real one and a plain-arithmetic reference.
module tb_xc_malu_divrem_seq;
    import xc_malu_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    always #5 clock = ~clock;

    xc_malu_divrem_seq_if bus ();

    logic               step_valid, step_signed, step_flush, step_ready;
    logic [31:0]        step_rs1, step_rs2, step_arg_0, step_arg_1;
    logic [31:0]        step_n_arg_0, step_n_arg_1;
    logic [COUNT_W-1:0] step_count;
    logic [63:0]        step_acc, step_n_acc;

    xc_malu_divrem_seq #(.BYPASS_DIV0(1'b1)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .flush        (flush),
        .bus          (bus),
        .step_valid   (step_valid),
        .step_signed  (step_signed),
        .step_flush   (step_flush),
        .step_rs1     (step_rs1),
        .step_rs2     (step_rs2),
        .step_count   (step_count),
        .step_acc     (step_acc),
        .step_arg_0   (step_arg_0),
        .step_arg_1   (step_arg_1),
        .step_n_acc   (step_n_acc),
        .step_n_arg_0 (step_n_arg_0),
        .step_n_arg_1 (step_n_arg_1),
        .step_ready   (step_ready)
    );

    // Step core model: first valid cycle loads |rs1|, |rs2|<<31; then one
    // restoring-division bit per cycle; ready once count reaches 32.
    logic        prev_valid;
    logic [31:0] abs1, abs2;

    always_ff @(posedge clock) begin
        prev_valid <= (resetn && !step_flush) ? step_valid : 1'b0;
    end

    always_comb begin
        abs1         = (step_signed && step_rs1[31]) ? -step_rs1 : step_rs1;
        abs2         = (step_signed && step_rs2[31]) ? -step_rs2 : step_rs2;
        step_n_acc   = step_acc >> 1;
        step_n_arg_0 = step_arg_0;
        step_n_arg_1 = {step_arg_1[30:0], 1'b0};
        if (!prev_valid) begin
            step_n_acc   = {1'b0, abs2, 31'd0};
            step_n_arg_0 = abs1;
            step_n_arg_1 = 32'd0;
        end else if ({32'd0, step_arg_0} >= step_acc) begin
            step_n_arg_0    = step_arg_0 - step_acc[31:0];
            step_n_arg_1[0] = 1'b1;
        end
    end

    assign step_ready = step_valid && prev_valid && (step_count == COUNT_W'(32));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) begin
            return op_is_rem(xc_op_e'(op)) ? a : 32'hFFFF_FFFF;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (xc_op_e'(op))
            XC_DIV:  return 32'(sa / sb);
            XC_REM:  return 32'(sa % sb);
            XC_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    // Issue one request from IDLE; returns result and cycles from accept to rsp_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int w;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!bus.req_ready) check("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 1) bus.req_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 200);
        if (!bus.rsp_valid) check("rsp_valid_timeout", {31'd0, bus.rsp_valid}, 32'd1);
        res = bus.rsp_result;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] res, a, b;
    logic [1:0]  op;
    int          lat, hits;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_rs1   = 32'd0;
        bus.req_rs2   = 32'd0;
        bus.rsp_ready = 1'b1;

        vecs[0]  = '{XC_DIVU, 32'd100,        32'd7,        32'd14,        36};
        vecs[1]  = '{XC_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 36};
        vecs[2]  = '{XC_REMU, 32'hFFFF_FFF9,  32'd2,        32'd1,         36};
        vecs[3]  = '{XC_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 36};
        vecs[4]  = '{XC_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         36};
        vecs[5]  = '{XC_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF, 2};
        vecs[6]  = '{XC_REM,  32'd5,          32'd0,        32'd5,         2};
        vecs[7]  = '{XC_REMU, 32'd7,          32'd0,        32'd7,         2};
        vecs[8]  = '{XC_DIV,  32'hFFFF_FFEC,  32'd4,        32'hFFFF_FFFB, 36};
        vecs[9]  = '{XC_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 36};
        vecs[10] = '{XC_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         36};
        vecs[11] = '{XC_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 36};

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_step_valid", {31'd0, step_valid}, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        check("rst_acc_lo", step_acc[31:0], 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].rs1, vecs[i].rs2, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 1000));
                default: a = $urandom;
            endcase
            run_op(op, a, b, res, lat);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), res, ref_model(op, a, b));
            check($sformatf("rnd%0d_latency", i), 32'(lat), (b == 32'd0) ? 32'd2 : 32'd36);
        end

        // Flush mid-run: abort, no stale response, then a clean op.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = XC_DIVU;
        bus.req_rs1   = 32'd1000;
        bus.req_rs2   = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
        end
        check("run10_step_valid", {31'd0, step_valid}, 32'd1);
        check("run10_step_signed", {31'd0, step_signed}, 32'd0);
        check("run10_count", 32'(step_count), 32'd8);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("flush_step_valid", {31'd0, step_valid}, 32'd0);
        check("flush_count", 32'(step_count), 32'd0);
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.rsp_valid) hits++;
        end
        check("flush_no_stale_rsp", 32'(hits), 32'd0);
        run_op(XC_DIV, 32'd20, 32'd4, res, lat);
        check("post_flush_result", res, 32'd5);
        check("post_flush_latency", 32'(lat), 32'd36);

        // Flush wins over an accept in the same cycle.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = XC_DIV;
        bus.req_rs1   = 32'd9;
        bus.req_rs2   = 32'd3;
        flush         = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        check("flush_accept_idle", {31'd0, bus.req_ready}, 32'd1);
        check("flush_accept_no_run", {31'd0, step_valid}, 32'd0);

        // Response backpressure: result held, no new request accepted.
        bus.rsp_ready = 1'b0;
        run_op(XC_DIVU, 32'd100, 32'd7, res, lat);
        check("bp_first_result", res, 32'd14);
        bus.req_valid = 1'b1;
        bus.req_op    = XC_DIVU;
        bus.req_rs1   = 32'd50;
        bus.req_rs2   = 32'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("bp%0d_rsp_valid", c), {31'd0, bus.rsp_valid}, 32'd1);
            check($sformatf("bp%0d_result", c), bus.rsp_result, 32'd14);
            check($sformatf("bp%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        check("bp_consumed_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_consumed_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("bp_no_run", {31'd0, step_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
